// File: rtl/vga_sprite_engine.sv
// VGA timing generator with one rectangular sprite. Sprite position is taken from a
// host strobe (manual) or bounced around the screen (bounce), updating only at frame_tick.
module vga_sprite_engine #(
  parameter int          CLK_DIV      = 2,
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          SPRITE_W     = 32,
  parameter int          SPRITE_H     = 32,
  parameter int          STEP         = 1,
  parameter logic [23:0] SPRITE_COLOR = 24'hFF0000,
  parameter logic [23:0] BG_COLOR     = 24'h0000FF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       pos_load,
  input  logic [9:0] pos_x_in,
  input  logic [9:0] pos_y_in,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       clockVGA,
  output logic       frame_tick,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int XMAX    = H_ACTIVE - SPRITE_W;
  localparam int YMAX    = V_ACTIVE - SPRITE_H;

  localparam logic [9:0]         XMAX_U = 10'(XMAX);
  localparam logic [9:0]         YMAX_U = 10'(YMAX);
  localparam logic signed [10:0] XMAX_S = 11'(XMAX);
  localparam logic signed [10:0] YMAX_S = 11'(YMAX);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [H_W-1:0]   h_cnt_q, h_cnt_d;
  logic [V_W-1:0]   v_cnt_q, v_cnt_d;
  logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [23:0]      rgb_q, rgb_d;
  logic [9:0]       sx_q, sx_d, sy_q, sy_d;
  logic             dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [9:0]       pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic             pending_q, pending_d;

  logic             pix_ce, h_last, v_last, visible, hit;
  logic [11:0]      h12, v12, sx12, sy12;
  logic [9:0]       ld_x, ld_y;
  logic signed [10:0] nx, ny;

  // Pixel clock enable and raster counters
  always_comb begin
    pix_ce    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    h_last    = (h_cnt_q == H_W'(H_TOTAL - 1));
    v_last    = (v_cnt_q == V_W'(V_TOTAL - 1));
    div_cnt_d = pix_ce ? '0 : div_cnt_q + DIV_W'(1);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (pix_ce) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + V_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + H_W'(1);
      end
    end
  end

  // Pixel decode; all four video outputs are captured together one pixel later
  always_comb begin
    h12     = 12'(h_cnt_q);
    v12     = 12'(v_cnt_q);
    sx12    = {2'b00, sx_q};
    sy12    = {2'b00, sy_q};
    visible = (h12 < 12'(H_ACTIVE)) && (v12 < 12'(V_ACTIVE));
    hit     = visible && (h12 >= sx12) && (h12 < sx12 + 12'(SPRITE_W))
                      && (v12 >= sy12) && (v12 < sy12 + 12'(SPRITE_H));
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (pix_ce) begin
      hs_d      = !((h12 >= 12'(H_ACTIVE + H_FP)) && (h12 < 12'(H_ACTIVE + H_FP + H_SYNC)));
      vs_d      = !((v12 >= 12'(V_ACTIVE + V_FP)) && (v12 < 12'(V_ACTIVE + V_FP + V_SYNC)));
      blank_n_d = visible;
      rgb_d     = hit ? SPRITE_COLOR : (visible ? BG_COLOR : 24'h000000);
    end
  end

  assign frame_tick = pix_ce && h_last && (v_cnt_q == V_W'(V_ACTIVE - 1));

  // pos_load is a single-cycle strobe with no back-pressure: the request is always
  // accepted, and a newer request overwrites any one not yet applied.
  always_comb begin
    pend_x_d  = pend_x_q;
    pend_y_d  = pend_y_q;
    pending_d = pending_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    dx_neg_d  = dx_neg_q;
    dy_neg_d  = dy_neg_q;
    ld_x      = pos_load ? pos_x_in : pend_x_q;
    ld_y      = pos_load ? pos_y_in : pend_y_q;
    nx        = $signed({1'b0, sx_q}) + (dx_neg_q ? -STEP_S : STEP_S);
    ny        = $signed({1'b0, sy_q}) + (dy_neg_q ? -STEP_S : STEP_S);
    if (frame_tick && !mode) begin
      if (pos_load || pending_q) begin
        sx_d = (ld_x > XMAX_U) ? XMAX_U : ld_x;
        sy_d = (ld_y > YMAX_U) ? YMAX_U : ld_y;
      end
      pending_d = 1'b0;
    end else begin
      if (frame_tick) begin
        // Bounce: clamp at the edge and reverse; the next step moves away from it
        if (nx > XMAX_S) begin
          sx_d     = XMAX_U;
          dx_neg_d = 1'b1;
        end else if (nx < 11'sd0) begin
          sx_d     = 10'd0;
          dx_neg_d = 1'b0;
        end else begin
          sx_d = nx[9:0];
        end
        if (ny > YMAX_S) begin
          sy_d     = YMAX_U;
          dy_neg_d = 1'b1;
        end else if (ny < 11'sd0) begin
          sy_d     = 10'd0;
          dy_neg_d = 1'b0;
        end else begin
          sy_d = ny[9:0];
        end
      end
      if (pos_load) begin
        pend_x_d  = pos_x_in;
        pend_y_d  = pos_y_in;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= 24'h000000;
      sx_q      <= 10'd0;
      sy_q      <= 10'd0;
      dx_neg_q  <= 1'b0;
      dy_neg_q  <= 1'b0;
      pend_x_q  <= 10'd0;
      pend_y_q  <= 10'd0;
      pending_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      dx_neg_q  <= dx_neg_d;
      dy_neg_q  <= dy_neg_d;
      pend_x_q  <= pend_x_d;
      pend_y_q  <= pend_y_d;
      pending_q <= pending_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign red         = rgb_q[23:16];
  assign green       = rgb_q[15:8];
  assign blue        = rgb_q[7:0];
  assign clockVGA    = (div_cnt_q >= DIV_W'(CLK_DIV / 2));
  assign sprite_x    = sx_q;
  assign sprite_y    = sy_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine on a reduced raster; a pixel-index reference model
// predicts every clock's outputs into a queue that a negedge monitor checks.
module tb_vga_sprite_engine;

  localparam int D = 2;
  localparam int HA = 32, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 24, VFP = 1, VS = 2, VBP = 1;
  localparam int SW = 8, SH = 8, STEP = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int XMAX = HA - SW, YMAX = VA - SH;
  localparam int MIDPIX = 5 * HT + 10;
  localparam logic [23:0] SC = 24'hFF0000, BC = 24'h0000FF;
  localparam int W = 49;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, mode, pos_load;
  logic [9:0] pos_x_in, pos_y_in;
  logic       vga_hs, vga_vs, vga_blank_n, clockVGA, frame_tick;
  logic [7:0] red, green, blue;
  logic [9:0] sprite_x, sprite_y;

  vga_sprite_engine #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SPRITE_W(SW), .SPRITE_H(SH), .STEP(STEP),
    .SPRITE_COLOR(SC), .BG_COLOR(BC)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .pos_load(pos_load),
    .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .red(red), .green(green), .blue(blue), .clockVGA(clockVGA),
    .frame_tick(frame_tick), .sprite_x(sprite_x), .sprite_y(sprite_y)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model: t = clocks since reset, everything else derived from it
  int t, sx, sy, pend_x, pend_y, nt;
  bit dxn, dyn, pending;

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit is_tick();
    return ((t % D) == D - 1) && (((t / D) % FRAME) == VA * HT - 1);
  endfunction

  function automatic logic [W-1:0] expect_now();
    int p, q, h, v;
    logic hs, vs, bl, ck, tk;
    logic [23:0] rgb;
    p = t / D;
    hs = 1'b1; vs = 1'b1; bl = 1'b0; rgb = 24'h0;
    if (p > 0) begin
      q  = (p - 1) % FRAME;
      h  = q % HT;
      v  = q / HT;
      hs = !(h >= HA + HFP && h < HA + HFP + HS);
      vs = !(v >= VA + VFP && v < VA + VFP + VS);
      bl = (h < HA) && (v < VA);
      if (bl) rgb = (h >= sx && h < sx + SW && v >= sy && v < sy + SH) ? SC : BC;
    end
    ck = (t % D) >= D / 2;
    tk = is_tick();
    return {hs, vs, bl, rgb, ck, tk, 10'(sx), 10'(sy)};
  endfunction

  task automatic model_step(input bit rst, input bit md, input bit ld, input int lx, input int ly);
    int nx, ny;
    bit tk;
    tk = is_tick();
    if (rst) begin
      t = 0; sx = 0; sy = 0; dxn = 0; dyn = 0;
      pending = 0; pend_x = 0; pend_y = 0;
      return;
    end
    if (tk) begin
      nt++;
      if (!md) begin
        if (ld) begin
          sx = clampi(lx, XMAX); sy = clampi(ly, YMAX);
        end else if (pending) begin
          sx = clampi(pend_x, XMAX); sy = clampi(pend_y, YMAX);
        end
        pending = 0;
      end else begin
        nx = sx + (dxn ? -STEP : STEP);
        ny = sy + (dyn ? -STEP : STEP);
        if (nx > XMAX) begin sx = XMAX; dxn = 1; end
        else if (nx < 0) begin sx = 0; dxn = 0; end
        else sx = nx;
        if (ny > YMAX) begin sy = YMAX; dyn = 1; end
        else if (ny < 0) begin sy = 0; dyn = 0; end
        else sy = ny;
        if (ld) begin pend_x = lx; pend_y = ly; pending = 1; end
      end
    end else if (ld) begin
      pend_x = lx; pend_y = ly; pending = 1;
    end
    t++;
  endtask

  task automatic drive_load(input int x, input int y);
    pos_load = 1'b1;
    pos_x_in = 10'(x);
    pos_y_in = 10'(y);
  endtask

  // driver + model
  initial begin
    int cyc;
    bit mid, tk, rst_done;
    reset = 1'b1; mode = 1'b0; pos_load = 1'b0; pos_x_in = '0; pos_y_in = '0;
    t = 0; sx = 0; sy = 0; dxn = 0; dyn = 0; pending = 0; pend_x = 0; pend_y = 0; nt = 0;
    cyc = 0; rst_done = 0;
    while (nt < 21 && cyc < 90000) begin
      @(posedge clk); #1;
      exp_q.push_back(expect_now());
      mid = (((t / D) % FRAME) == MIDPIX) && ((t % D) == 0);
      tk  = is_tick();
      reset = (cyc < 2);
      if (nt == 19 && mid && !rst_done) begin
        reset = 1'b1;
        rst_done = 1;
      end
      mode = (nt >= 6 && nt < 17);
      pos_load = 1'b0;
      if (nt == 2 && mid) drive_load(20, 10);
      if (nt == 3 && mid) drive_load(70, 47);
      if (nt == 4 && tk)  drive_load($urandom_range(0, 1023), $urandom_range(0, 1023));
      if (nt == 5 && mid) drive_load(0, 0);
      if (mode && $urandom_range(0, 499) == 0)
        drive_load($urandom_range(0, 1023), $urandom_range(0, 1023));
      if (nt == 17 && mid) drive_load($urandom_range(0, 40), $urandom_range(0, 30));
      if (!pos_load && $urandom_range(0, 3) == 0) begin
        pos_x_in = 10'($urandom_range(0, 1023));
        pos_y_in = 10'($urandom_range(0, 1023));
      end
      model_step(reset, mode, pos_load, int'(pos_x_in), int'(pos_y_in));
      cyc++;
    end
    reset = 1'b0; pos_load = 1'b0;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (cyc >= 90000) begin
      n_fail++;
      $display("FAIL timeout: frame ticks seen %0d, required 21", nt);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // monitor
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {vga_hs, vga_vs, vga_blank_n, red, green, blue, clockVGA, frame_tick, sprite_x, sprite_y};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL pix @%0t: got hs=%b vs=%b bl=%b rgb=%h ck=%b tk=%b x=%0d y=%0d, required hs=%b vs=%b bl=%b rgb=%h ck=%b tk=%b x=%0d y=%0d",
                   $time, a[48], a[47], a[46], a[45:22], a[21], a[20], a[19:10], a[9:0],
                   e[48], e[47], e[46], e[45:22], e[21], e[20], e[19:10], e[9:0]);
          if (n_fail >= 50) begin
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
          end
        end
      end
    end
  end

endmodule
